// File: rtl/vga_display_gen.sv
// vga_display_gen: VGA timing generator with built-in test patterns.
//
// A clock divider produces one pixel tick every CLK_DIV clocks. The tick
// advances the horizontal / vertical counters. Sync, data-enable, colour and
// frame_start are decoded from the counters and registered, so every output
// trails the counter state it represents by exactly one clock.
//
// Patterns (selected by mode, latched once per frame at pixel (0,0)):
//   0 colour bars, 1 checkerboard, 2 horizontal gradient, 3 black.
//
// Optional feature: define VGA_SCROLL_EN to add a horizontal scroll offset
// that advances by one pixel per frame and wraps at H_ACTIVE.

module vga_display_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic           CLK_100M,
  input  logic           RST,
  input  logic [1:0]     mode,
  output logic           hsync_pin,
  output logic           vsync_pin,
  output logic [R_W-1:0] red,
  output logic [G_W-1:0] green,
  output logic [B_W-1:0] blue,
  output logic           de,
  output logic           frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 10 bits so pattern bits x[8:0] and y[5] always exist.
  localparam int HW       = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW       = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int RGB_W    = R_W + G_W + B_W;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    mode_q;
  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;

  logic [HW-1:0]    x_eff_p0;
  logic             de_p0;
  logic             hs_act_p0;
  logic             vs_act_p0;
  logic             fs_p0;
  logic [RGB_W-1:0] rgb_p0;

  // Pattern generator: colour for effective column x and row bit y5.
  function automatic logic [RGB_W-1:0] pattern_pix(input logic [1:0]    m,
                                                   input logic [HW-1:0] x,
                                                   input logic          y5);
    logic [2:0]       bar;
    logic [RGB_W-1:0] pix;
    bar = 3'(x / HW'(BAR_W));
    pix = '0;
    case (m)
      2'd0:    pix = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
      2'd1:    pix = {RGB_W{x[5] ^ y5}};
      2'd2:    pix = {x[8 -: R_W], x[8 -: G_W], x[8 -: B_W]};
      default: pix = '0;
    endcase
    return pix;
  endfunction

  assign tick       = (div_cnt == DW'(CLK_DIV - 1));
  assign h_last     = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last     = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_wrap = tick && h_last && v_last;

  // Pixel clock divider: counts 0..CLK_DIV-1, tick on the last count.
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster counters: h advances every tick, v advances when h wraps.
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Pattern select is captured only as the raster enters (0,0).
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      mode_q <= 2'd0;
    end else if (frame_wrap) begin
      mode_q <= mode;
    end
  end

`ifdef VGA_SCROLL_EN
  logic [HW-1:0] offset;
  logic [HW:0]   x_sum;

  // Scroll offset steps by one pixel per frame, wrapping at H_ACTIVE.
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      offset <= '0;
    end else if (frame_wrap) begin
      offset <= (offset == HW'(H_ACTIVE - 1)) ? '0 : offset + 1'b1;
    end
  end

  // Column seen by the pattern: (h + offset) mod H_ACTIVE; both terms are
  // below H_ACTIVE in the visible area, so one conditional subtract is enough.
  always_comb begin
    x_sum    = {1'b0, h_cnt} + {1'b0, offset};
    x_eff_p0 = HW'((x_sum >= (HW+1)'(H_ACTIVE)) ? x_sum - (HW+1)'(H_ACTIVE) : x_sum);
  end
`else
  assign x_eff_p0 = h_cnt;
`endif

  // Stage p0: combinational decode of the current counter state.
  always_comb begin
    hs_act_p0 = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    vs_act_p0 = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
    de_p0     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    fs_p0     = (div_cnt == '0) && (h_cnt == '0) && (v_cnt == '0);
    rgb_p0    = de_p0 ? pattern_pix(mode_q, x_eff_p0, v_cnt[5]) : '0;
  end

  // Stage p1: registered outputs, one clock behind the counters.
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      hsync_pin   <= ~HS_POL;
      vsync_pin   <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      hsync_pin              <= hs_act_p0 ? HS_POL : ~HS_POL;
      vsync_pin              <= vs_act_p0 ? VS_POL : ~VS_POL;
      de                     <= de_p0;
      frame_start            <= fs_p0;
      {red, green, blue}     <= rgb_p0;
    end
  end

endmodule

// File: tb/tb_vga_display_gen.sv
// Bench for vga_display_gen: three instances (reduced timing with scrolling
// sensitivity, default 640x480 timing, tiny 16-pixel raster) checked every
// clock against a closed-form raster model, plus literal spot checks.

module tb_vga_display_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  // Instance A: reduced raster, sync polarity high on hsync.
  localparam int A_HA = 128, A_HFP = 4, A_HS = 8, A_HBP = 4;
  localparam int A_VA = 36,  A_VFP = 1, A_VS = 2, A_VBP = 1;
  localparam int A_DIV = 2;
  localparam int FC_A = (A_HA+A_HFP+A_HS+A_HBP) * (A_VA+A_VFP+A_VS+A_VBP) * A_DIV;
  // Instance D: all defaults.
  localparam int FC_D = 800 * 525 * 4;
  // Instance S: tiny raster, CLK_DIV=1, vsync polarity high.
  localparam int FC_S = 22 * 7 * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_ds = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_d = 2'd0, mode_s = 2'd0;

  logic hs_a, vs_a, de_a, fs_a, hs_d, vs_d, de_d, fs_d, hs_s, vs_s, de_s, fs_s;
  logic [2:0] r_a, g_a, r_d, g_d, r_s, g_s;
  logic [1:0] b_a, b_d, b_s;

  int errors = 0;
  int checks = 0;

  vga_display_gen #(.H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
                    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
                    .CLK_DIV(A_DIV), .HS_POL(1'b1), .VS_POL(1'b0)) dut_a (
    .CLK_100M(clk), .RST(rst_a), .mode(mode_a), .hsync_pin(hs_a), .vsync_pin(vs_a),
    .red(r_a), .green(g_a), .blue(b_a), .de(de_a), .frame_start(fs_a));

  vga_display_gen dut_d (
    .CLK_100M(clk), .RST(rst_ds), .mode(mode_d), .hsync_pin(hs_d), .vsync_pin(vs_d),
    .red(r_d), .green(g_d), .blue(b_d), .de(de_d), .frame_start(fs_d));

  vga_display_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b1)) dut_s (
    .CLK_100M(clk), .RST(rst_ds), .mode(mode_s), .hsync_pin(hs_s), .vsync_pin(vs_s),
    .red(r_s), .green(g_s), .blue(b_s), .de(de_s), .frame_start(fs_s));

  // Expected outputs for clock c after reset release, straight from the
  // raster rules: pixel = c/div, position from pixel index, pattern from x/y.
  function automatic exp_t model(input int c, input int m, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va, input int vfp,
                                 input int vsw, input int vbp, input int dv,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht, vt, fc, p, h, v, f, off, x, bar;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    fc = ht * vt * dv;
    p  = c / dv;
    h  = p % ht;
    v  = (p / ht) % vt;
    f  = c / fc;
    off = 0;
`ifdef VGA_SCROLL_EN
    off = f % ha;
`endif
    x = (h + off) % ha;
    e.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hp : ~hp;
    e.vs = (v >= va + vfp && v < va + vfp + vsw) ? vp : ~vp;
    e.de = (h < ha) && (v < va);
    e.fs = (c % fc == 0);
    e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
    if (e.de) begin
      case (m)
        0: begin
          bar = x / (ha / 8);
          if ((bar & 4) != 0) e.r = 8'd7;
          if ((bar & 2) != 0) e.g = 8'd7;
          if ((bar & 1) != 0) e.b = 8'd3;
        end
        1: if (((x / 32) + (v / 32)) % 2 == 1) begin
          e.r = 8'd7; e.g = 8'd7; e.b = 8'd3;
        end
        2: begin
          e.r = 8'((x % 512) / 64);
          e.g = 8'((x % 512) / 64);
          e.b = 8'((x % 512) / 128);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t rexp(input bit hp, input bit vp);
    exp_t e;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    return e;
  endfunction

  function automatic exp_t pk(input logic hs, input logic vs, input logic de_i, input logic fs,
                              input logic [2:0] r, input logic [2:0] g, input logic [1:0] b);
    exp_t e;
    e.hs = hs; e.vs = vs; e.de = de_i; e.fs = fs;
    e.r = 8'(r); e.g = 8'(g); e.b = 8'(b);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t want, input exp_t got);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got hs=%0b vs=%0b de=%0b fs=%0b rgb=%0d/%0d/%0d, required hs=%0b vs=%0b de=%0b fs=%0b rgb=%0d/%0d/%0d",
               nm, $time, got.hs, got.vs, got.de, got.fs, got.r, got.g, got.b,
               want.hs, want.vs, want.de, want.fs, want.r, want.g, want.b);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, required %0d", nm, $time, got, want);
    end
  endtask

  // Model state: clock index since release and per-frame latched mode.
  int a_n = 0, a_mode = 0, a_mprev = 0;
  int d_n = 0, d_mode = 0, d_mprev = 0;
  int s_n = 0, s_mode = 0, s_mprev = 0;
  int g_c = -1;
  exp_t ea = '0, ed = '0, es = '0;

  initial forever begin
    @(posedge clk);
    if (rst_a) begin
      a_n = 0; a_mode = 0; a_mprev = 0; ea = rexp(1'b1, 1'b0);
    end else begin
      if (a_n > 0 && a_n % FC_A == 0) a_mode = a_mprev;
      ea = model(a_n, a_mode, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_DIV, 1'b1, 1'b0);
      a_mprev = int'(mode_a);
      a_n++;
    end
    if (rst_ds) begin
      d_n = 0; d_mode = 0; d_mprev = 0; ed = rexp(1'b0, 1'b0);
      s_n = 0; s_mode = 0; s_mprev = 0; es = rexp(1'b0, 1'b1);
      g_c = -1;
    end else begin
      if (d_n > 0 && d_n % FC_D == 0) d_mode = d_mprev;
      ed = model(d_n, d_mode, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0);
      d_mprev = int'(mode_d);
      if (s_n > 0 && s_n % FC_S == 0) s_mode = s_mprev;
      es = model(s_n, s_mode, 16, 2, 2, 2, 4, 1, 1, 1, 1, 1'b0, 1'b1);
      s_mprev = int'(mode_s);
      g_c = d_n;
      d_n++;
      s_n++;
    end
  end

  // Every clock, away from the active edge, compare all three instances.
  initial forever begin
    @(negedge clk);
    cmp("a_out", rst_a  ? rexp(1'b1, 1'b0) : ea, pk(hs_a, vs_a, de_a, fs_a, r_a, g_a, b_a));
    cmp("d_out", rst_ds ? rexp(1'b0, 1'b0) : ed, pk(hs_d, vs_d, de_d, fs_d, r_d, g_d, b_d));
    cmp("s_out", rst_ds ? rexp(1'b0, 1'b1) : es, pk(hs_s, vs_s, de_s, fs_s, r_s, g_s, b_s));
  end

  // Advance to just after the edge that presents clock index n.
  task automatic at(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (g_c != n && guard < 200000);
    if (g_c != n) chk("wait_timeout", g_c, n);
  endtask

  task automatic rgb_a(input string nm, input int r, input int g, input int b);
    chk({nm, "_r"}, int'(r_a), r); chk({nm, "_g"}, int'(g_a), g); chk({nm, "_b"}, int'(b_a), b);
  endtask
  task automatic rgb_d(input string nm, input int r, input int g, input int b);
    chk({nm, "_r"}, int'(r_d), r); chk({nm, "_g"}, int'(g_d), g); chk({nm, "_b"}, int'(b_d), b);
  endtask
  task automatic rgb_s(input string nm, input int r, input int g, input int b);
    chk({nm, "_r"}, int'(r_s), r); chk({nm, "_g"}, int'(g_s), g); chk({nm, "_b"}, int'(b_s), b);
  endtask

  initial begin
    int n, fs_edge, hs_edge;
    rst_a = 1'b1;
    rst_ds = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_hsync", int'(hs_a), 0);
    chk("rst_a_vsync", int'(vs_a), 1);
    chk("rst_d_hsync", int'(hs_d), 1);
    chk("rst_s_vsync", int'(vs_s), 0);
    chk("rst_d_de", int'(de_d), 0);
    chk("rst_d_fs", int'(fs_d), 0);
    rst_a = 1'b0;
    rst_ds = 1'b0;

    at(0);
    chk("d_fs0", int'(fs_d), 1); chk("a_fs0", int'(fs_a), 1); chk("s_fs0", int'(fs_s), 1);
    chk("d_de0", int'(de_d), 1); rgb_d("d_px0", 0, 0, 0);
    at(100);   mode_a = 2'd2;
    at(154);   chk("s_fs_f2", int'(fs_s), 1); rgb_s("s_f2_px0", 0, 0, 0);
`ifdef VGA_SCROLL_EN
    at(155);   rgb_s("s_f2_px1", 0, 0, 3);
`else
    at(155);   rgb_s("s_f2_px1", 0, 0, 0);
`endif
    at(320);   rgb_d("d_px80", 0, 0, 3);
    at(2240);  rgb_d("d_px560", 7, 7, 3);
`ifdef VGA_SCROLL_EN
    at(2310);  rgb_s("s_f16_px0", 7, 7, 3);
`else
    at(2310);  rgb_s("s_f16_px0", 0, 0, 0);
`endif
    at(2464);  chk("s_fs_f17", int'(fs_s), 1); rgb_s("s_f17_px0", 0, 0, 0);
    at(2466);  rgb_s("s_f17_px2", 0, 0, 3);
    at(2623);  chk("d_hs_pre", int'(hs_d), 1);
    at(2624);  chk("d_hs_fall", int'(hs_d), 0);
    at(2800);  chk("d_de_px700", int'(de_d), 0); rgb_d("d_px700", 0, 0, 0);
    at(3007);  chk("d_hs_low_end", int'(hs_d), 0);
    at(3008);  chk("d_hs_rise", int'(hs_d), 1);
    at(5823);  chk("d_hs_pre2", int'(hs_d), 1);
    at(5824);  chk("d_hs_fall2", int'(hs_d), 0);
    at(10655); chk("a_vs_pre", int'(vs_a), 1);
    at(10656); chk("a_vs_fall", int'(vs_a), 0);
    at(11231); chk("a_vs_low_end", int'(vs_a), 0);
    at(11232); chk("a_vs_rise", int'(vs_a), 1);
    at(11520); chk("a_fs_f1", int'(fs_a), 1);
    at(11521); chk("a_fs_f1_next", int'(fs_a), 0);
    at(12584); chk("a_grad_de", int'(de_a), 1); rgb_a("a_grad_x100", 1, 1, 0);
    at(14400); mode_a = 2'd3;
    at(24292); chk("a_black_de", int'(de_a), 1); rgb_a("a_mode3", 0, 0, 0);
    at(24480); mode_a = 2'd0;
    at(40320); mode_a = 2'd1;
    at(41792); rgb_a("a_bars_after_switch", 0, 0, 3);
    at(46144); rgb_a("a_chk_32_0", 7, 7, 3);
    at(55360); chk("a_chk_de", int'(de_a), 1); rgb_a("a_chk_32_32", 0, 0, 0);
    at(55684);
    chk("a_pre_rst_de", int'(de_a), 1);
    rst_a = 1'b1;
    #1;
    chk("a_arst_hsync", int'(hs_a), 0);
    chk("a_arst_vsync", int'(vs_a), 1);
    chk("a_arst_de", int'(de_a), 0);
    chk("a_arst_fs", int'(fs_a), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    n = 0; fs_edge = -1; hs_edge = -1;
    while (n < 2000 && hs_edge < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (fs_a === 1'b1 && fs_edge < 0) fs_edge = n;
      if (hs_a === 1'b1) hs_edge = n;
    end
    chk("a_fs_after_rst", fs_edge, 1);
    chk("a_hs_after_rst", hs_edge, 265);
    repeat (50) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
